verlet_stepper: RTL and testbench

Position writer for the particle array: holds current and previous position of every node, advances them one Verlet step per `start`, and drives each updated position onto a valid/ready bus feeding the nodes' `in_x`/`in_y` inputs. Applies a constant per-step acceleration (gravity) and clamps positions to a bounding box. Sits between the simulation controller, which issues `start`, and the node array.

---
 rtl/verlet_pkg.sv | 26 ++
 rtl/verlet_alu.sv | 33 +++
 rtl/verlet_stepper.sv | 115 +++++++++++
 tb/tb_verlet_stepper.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/verlet_pkg.sv
// Shared types and helpers for the Verlet position stepper.
package verlet_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, EMIT, DONE} state_t;

  localparam int DEF_W = 16;

  // Clamp v into [lo, hi]; clamped reports whether the bound was applied.
  function automatic logic signed [31:0] sat_pos(
    input  logic signed [31:0] v,
    input  logic signed [31:0] lo,
    input  logic signed [31:0] hi,
    output logic               clamped
  );
    clamped = 1'b0;
    sat_pos = v;
    if (v < lo) begin
      sat_pos = lo;
      clamped = 1'b1;
    end else if (v > hi) begin
      sat_pos = hi;
      clamped = 1'b1;
    end
  endfunction

endpackage

// File: rtl/verlet_alu.sv
// Single-axis Verlet update: next = sat(2*x - px + acc), with a clamp flag.
module verlet_alu
  import verlet_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int ACC     = 0,
  parameter int POS_MIN = -1000,
  parameter int POS_MAX = 1000
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] px,
  output logic signed [W-1:0] next,
  output logic                clamped
);

  localparam int EW = W + 3;
  localparam logic signed [EW-1:0] ACC_E = EW'(ACC);

  logic signed [EW-1:0] x_e;
  logic signed [EW-1:0] px_e;
  logic signed [EW-1:0] n;
  logic signed [31:0]   s;

  // Three guard bits cover 2*x - px + acc without wrap for any W-bit inputs.
  always_comb begin
    x_e  = EW'(x);
    px_e = EW'(px);
    n    = (x_e <<< 1) - px_e + ACC_E;
    s    = sat_pos(32'(n), POS_MIN, POS_MAX, clamped);
    next = W'(s);
  end

endmodule

// File: rtl/verlet_stepper.sv
// Holds per-node current/previous positions, advances them one Verlet step per
// start, and streams each updated position over a valid/ready bus.
module verlet_stepper
  import verlet_pkg::*;
#(
  parameter int N_NODES = 4,
  parameter int W       = DEF_W,
  parameter int ACC_X   = 0,
  parameter int ACC_Y   = -1,
  parameter int POS_MIN = -1000,
  parameter int POS_MAX = 1000,
  localparam int IW     = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  input  logic [IW-1:0]       load_idx,
  input  logic signed [W-1:0] load_x,
  input  logic signed [W-1:0] load_y,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IW-1:0]       out_idx,
  output logic signed [W-1:0] out_x,
  output logic signed [W-1:0] out_y
);

  localparam logic [IW:0]   N_LIM = (IW+1)'(N_NODES);
  localparam logic [IW-1:0] LAST  = IW'(N_NODES - 1);

  state_t state, state_n;
  logic [IW-1:0] idx;

  logic signed [W-1:0] x_mem  [N_NODES];
  logic signed [W-1:0] px_mem [N_NODES];
  logic signed [W-1:0] y_mem  [N_NODES];
  logic signed [W-1:0] py_mem [N_NODES];

  logic signed [W-1:0] nx, ny;
  logic                cx, cy;
  logic                load_ok;

  assign load_ok = load_valid && ({1'b0, load_idx} < N_LIM);

  verlet_alu #(.W(W), .ACC(ACC_X), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX)) u_alu_x (
    .x(x_mem[idx]), .px(px_mem[idx]), .next(nx), .clamped(cx)
  );

  verlet_alu #(.W(W), .ACC(ACC_Y), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX)) u_alu_y (
    .x(y_mem[idx]), .px(py_mem[idx]), .next(ny), .clamped(cy)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = COMPUTE;
      COMPUTE: state_n = EMIT;
      EMIT:    if (out_ready) state_n = (idx == LAST) ? DONE : COMPUTE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = (state == EMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      out_idx <= '0;
      out_x   <= '0;
      out_y   <= '0;
      for (int i = 0; i < N_NODES; i++) begin
        x_mem[i]  <= '0;
        px_mem[i] <= '0;
        y_mem[i]  <= '0;
        py_mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // Loading x and px together gives the node zero velocity.
          if (load_ok) begin
            x_mem[load_idx]  <= load_x;
            px_mem[load_idx] <= load_x;
            y_mem[load_idx]  <= load_y;
            py_mem[load_idx] <= load_y;
          end
          if (start) idx <= '0;
        end
        COMPUTE: begin
          // A clamped axis gets px = x so the wall absorbs all velocity.
          x_mem[idx]  <= nx;
          px_mem[idx] <= cx ? nx : x_mem[idx];
          y_mem[idx]  <= ny;
          py_mem[idx] <= cy ? ny : y_mem[idx];
          out_idx     <= idx;
          out_x       <= nx;
          out_y       <= ny;
        end
        EMIT: if (out_ready && idx != LAST) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_verlet_stepper.sv
// Directed bench for verlet_stepper: stepping, clamping, backpressure,
// ignored inputs while busy, mid-step reset and same-cycle load/start.
module tb_verlet_stepper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, load_valid, start, out_ready;
  logic [1:0]         load_idx, out_idx;
  logic signed [15:0] load_x, load_y, out_x, out_y;
  logic               busy, done, out_valid;

  logic               load_valid2, start2, out_ready2;
  logic [1:0]         load_idx2, out_idx2;
  logic signed [15:0] load_x2, load_y2, out_x2, out_y2;
  logic               busy2, done2, out_valid2;

  verlet_stepper dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_idx(load_idx),
    .load_x(load_x), .load_y(load_y), .start(start), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_x(out_x), .out_y(out_y)
  );

  verlet_stepper #(.N_NODES(3), .ACC_X(5)) dut2 (
    .clk(clk), .rst(rst), .load_valid(load_valid2), .load_idx(load_idx2),
    .load_x(load_x2), .load_y(load_y2), .start(start2), .busy(busy2), .done(done2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_idx(out_idx2),
    .out_x(out_x2), .out_y(out_y2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int em_idx [16];
  int em_x   [16];
  int em_y   [16];
  int n_em, done_cyc, n_done;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_node(input int i, input int xv, input int yv);
    chk($sformatf("emit%0d_idx", i), em_idx[i], i);
    chk($sformatf("emit%0d_x", i), em_x[i], xv);
    chk($sformatf("emit%0d_y", i), em_y[i], yv);
  endtask

  task automatic load(input logic [1:0] i, input logic signed [15:0] xv,
                      input logic signed [15:0] yv);
    load_valid = 1'b1; load_idx = i; load_x = xv; load_y = yv;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  // Issue start (optionally with a load), then watch one full step on dut.
  task automatic run_step(input int stall_node, input int stall_cyc, input bit poke,
                          input bit ld, input logic [1:0] li,
                          input logic signed [15:0] lx, input logic signed [15:0] ly);
    int cyc;
    int stalled;
    logic signed [15:0] sx, sy;
    n_em = 0; done_cyc = -1; n_done = 0; stalled = 0; sx = '0; sy = '0;
    load_valid = ld; load_idx = li; load_x = lx; load_y = ly;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0; start = 1'b0; cyc = 1;
    while (done_cyc < 0 && cyc < 60) begin
      out_ready = 1'b1;
      if (poke && cyc == 3) begin
        start = 1'b1; load_valid = 1'b1; load_idx = 2'd0; load_x = 500; load_y = 500;
      end else begin
        start = 1'b0; load_valid = 1'b0;
      end
      chk("busy_during_step", busy, 1);
      if (out_valid && out_idx == stall_node && stalled < stall_cyc) begin
        if (stalled == 0) begin
          sx = out_x; sy = out_y;
        end else begin
          chk("stall_x_stable", out_x, sx);
          chk("stall_y_stable", out_y, sy);
        end
        out_ready = 1'b0;
        stalled++;
      end
      if (out_valid && out_ready && n_em < 16) begin
        em_idx[n_em] = out_idx; em_x[n_em] = out_x; em_y[n_em] = out_y;
        n_em++;
      end
      if (done) begin
        done_cyc = cyc;
        n_done++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; load_valid = 1'b0; out_ready = 1'b1;
    chk("done_within_budget", done_cyc >= 0, 1);
    repeat (3) begin
      chk("busy_after_done", busy, 0);
      chk("no_extra_done", done, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int c;
    rst = 1'b1; load_valid = 1'b0; load_idx = '0; load_x = '0; load_y = '0;
    start = 1'b0; out_ready = 1'b1;
    load_valid2 = 1'b0; load_idx2 = '0; load_x2 = '0; load_y2 = '0;
    start2 = 1'b0; out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst2_busy", busy2, 0);

    // First and second step from a node loaded at rest.
    load(2'd0, 16'sd10, 16'sd20);
    run_step(-1, 0, 1'b0, 1'b0, 2'd0, 16'sd0, 16'sd0);
    chk("s1_n_emit", n_em, 4);
    chk("s1_done_cyc", done_cyc, 9);
    chk_node(0, 10, 19); chk_node(1, 0, -1); chk_node(2, 0, -1); chk_node(3, 0, -1);

    run_step(-1, 0, 1'b0, 1'b0, 2'd0, 16'sd0, 16'sd0);
    chk("s2_n_emit", n_em, 4);
    chk("s2_done_cyc", done_cyc, 9);
    chk_node(0, 10, 17); chk_node(1, 0, -3); chk_node(2, 0, -3); chk_node(3, 0, -3);

    // Node1 near the floor; this step also stalls node2 for 5 cycles.
    load(2'd1, 16'sd0, -16'sd999);
    run_step(2, 5, 1'b0, 1'b0, 2'd0, 16'sd0, 16'sd0);
    chk("s3_n_emit", n_em, 4);
    chk("s3_done_cyc", done_cyc, 14);
    chk_node(0, 10, 14); chk_node(1, 0, -1000); chk_node(2, 0, -6); chk_node(3, 0, -6);

    // Clamped step, with start and a load poked while busy.
    run_step(-1, 0, 1'b1, 1'b0, 2'd0, 16'sd0, 16'sd0);
    chk("s4_n_emit", n_em, 4);
    chk("s4_n_done", n_done, 1);
    chk("s4_done_cyc", done_cyc, 9);
    chk_node(0, 10, 10); chk_node(1, 0, -1000); chk_node(2, 0, -10); chk_node(3, 0, -10);

    // Stays pinned at the wall: velocity was zeroed by the clamp.
    run_step(-1, 0, 1'b0, 1'b0, 2'd0, 16'sd0, 16'sd0);
    chk("s5_n_emit", n_em, 4);
    chk_node(0, 10, 5); chk_node(1, 0, -1000); chk_node(2, 0, -15); chk_node(3, 0, -15);

    // Reset during node1's EMIT.
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; c = 1;
    while (!(out_valid && out_idx == 2'd1) && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("reach_node1_emit", out_valid && out_idx == 2'd1, 1);
    out_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_x", out_x, 0);
    n_done = 0;
    repeat (12) begin
      if (done) n_done++;
      @(posedge clk); #1;
    end
    chk("midrst_no_done", n_done, 0);

    run_step(-1, 0, 1'b0, 1'b0, 2'd0, 16'sd0, 16'sd0);
    chk("s6_n_emit", n_em, 4);
    chk_node(0, 0, -1); chk_node(1, 0, -1); chk_node(2, 0, -1); chk_node(3, 0, -1);

    // Load and start in the same cycle.
    run_step(-1, 0, 1'b0, 1'b1, 2'd3, 16'sd4, 16'sd4);
    chk("s7_n_emit", n_em, 4);
    chk("s7_done_cyc", done_cyc, 9);
    chk_node(0, 0, -3); chk_node(1, 0, -3); chk_node(2, 0, -3); chk_node(3, 4, 3);

    // Three-node instance with ACC_X = 5: upper clamp and out-of-range load.
    load_valid2 = 1'b1; load_idx2 = 2'd3; load_x2 = 777; load_y2 = 777;
    @(posedge clk); #1;
    load_idx2 = 2'd0; load_x2 = 998; load_y2 = 0;
    @(posedge clk); #1;
    load_valid2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; c = 1; n_em = 0; done_cyc = -1;
    while (done_cyc < 0 && c < 40) begin
      if (out_valid2 && n_em < 16) begin
        em_idx[n_em] = out_idx2; em_x[n_em] = out_x2; em_y[n_em] = out_y2;
        n_em++;
      end
      if (done2) done_cyc = c;
      @(posedge clk); #1;
      c++;
    end
    chk("d2_n_emit", n_em, 3);
    chk("d2_done_cyc", done_cyc, 7);
    chk_node(0, 1000, -1); chk_node(1, 5, -1); chk_node(2, 5, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
